uart_tx_arb: RTL and testbench

- Round-robin arbiter that shares one uart transmitter's FIFO-read interface among NREQ first-word-fall-through transmit FIFOs.
- Grants one requester per message so lines from different sources never interleave on the serial line.
- Sits between per-source tx FIFOs and the uart tx_fifo_rd_data/tx_fifo_re/tx_fifo_ne ports.

---
 rtl/uart_tx_arb_if.sv | 22 ++
 rtl/uart_tx_arb.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// Requester-FIFO and uart-FIFO-read signal bundle for uart_tx_arb.
// slave = the arbiter, master = the FIFOs plus the uart that drive it.
interface uart_tx_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ*8-1:0] req_rd_data;
  logic [NREQ-1:0]   req_ne;
  logic [NREQ-1:0]   req_re;
  logic [7:0]        tx_fifo_rd_data;
  logic              tx_fifo_ne;
  logic              tx_fifo_re;

  modport slave (
    input  req_rd_data, req_ne, tx_fifo_re,
    output req_re, tx_fifo_rd_data, tx_fifo_ne
  );

  modport master (
    output req_rd_data, req_ne, tx_fifo_re,
    input  req_re, tx_fifo_rd_data, tx_fifo_ne
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter granting one FWFT tx FIFO per message to a shared uart.
// `UART_ARB_TAG_EN: each grant first sends an ASCII source tag (8'h30 + index).
module uart_tx_arb #(
  parameter int         NREQ      = 4,
  parameter logic [7:0] EOM       = 8'h0A,
  parameter int         MAX_BURST = 64,
  parameter int         TIMEOUT   = 4096
) (
  input  logic            clk,
  input  logic            reset_l,
  uart_tx_arb_if.slave    bus,
  output logic [NREQ-1:0] grant,
  output logic            busy
);
  // state | meaning
  // IDLE  | no grant, arbitrate among non-empty requesters
  // GRANT | granted FIFO drives the uart until EOM, burst cap or timeout
  // TAG   | (tag build) source tag byte offered before the message
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {IDLE, GRANT, TAG} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [7:0]      burst_q, burst_d;
  logic [15:0]     tmo_q, tmo_d;

  logic [IW-1:0]   win, cand;
  logic            found;
  logic [7:0]      head;
  logic            head_ne;
  logic            pop;
  logic            rel;

  // First non-empty requester at or after the rotation pointer, with wrap.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(rr_q) + k) % NREQ);
      if (!found && bus.req_ne[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    head    = '0;
    head_ne = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx_q == IW'(i)) begin
        head    = bus.req_rd_data[8*i +: 8];
        head_ne = bus.req_ne[i];
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    gidx_d              = gidx_q;
    rr_d                = rr_q;
    burst_d             = burst_q;
    tmo_d               = tmo_q;
    bus.tx_fifo_ne      = 1'b0;
    bus.tx_fifo_rd_data = '0;
    bus.req_re          = '0;
    pop                 = 1'b0;
    rel                 = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          for (int i = 0; i < NREQ; i++) grant_d[i] = (win == IW'(i));
          gidx_d  = win;
          rr_d    = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
          burst_d = '0;
          tmo_d   = '0;
`ifdef UART_ARB_TAG_EN
          state_d = TAG;
`else
          state_d = GRANT;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        bus.tx_fifo_ne      = 1'b1;
        bus.tx_fifo_rd_data = 8'h30 + 8'(gidx_q);
        if (bus.tx_fifo_re) state_d = GRANT;
      end
`endif
      GRANT: begin
        bus.tx_fifo_ne      = head_ne;
        bus.tx_fifo_rd_data = head;
        pop                 = bus.tx_fifo_re & head_ne;
        bus.req_re          = grant_q & {NREQ{pop}};
        // A pop wins over the empty-timeout in the same cycle.
        if (pop) begin
          burst_d = burst_q + 8'd1;
          tmo_d   = '0;
          rel     = (head == EOM) || (burst_d == 8'(MAX_BURST));
        end else if (!head_ne) begin
          if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
          rel = (tmo_d == 16'(TIMEOUT));
        end
        if (rel) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: queue models of the requester FIFOs, uart popping on demand.
// Build with UART_ARB_TAG_EN to exercise the tag-byte variant.
module tb_uart_tx_arb;
  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            reset_l;
  logic [NREQ-1:0] grant;
  logic            busy;

  uart_tx_arb_if #(.NREQ(NREQ)) bus ();

  uart_tx_arb #(
    .NREQ(NREQ), .EOM(8'h0A), .MAX_BURST(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_l(reset_l), .bus(bus), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]      fq [NREQ][$];
  logic [11:0]     rx_q [$];
  logic [7:0]      uart_q [$];
  logic            uart_re = 1'b0;

  logic [NREQ-1:0] o_grant, o_re;
  logic            o_busy, o_ne;
  logic [7:0]      o_data;

  task automatic load(input int idx, input string s);
    for (int k = 0; k < s.len(); k++) fq[idx].push_back(s[k]);
  endtask

  task automatic clear_models();
    for (int i = 0; i < NREQ; i++) fq[i].delete();
    rx_q.delete();
    uart_q.delete();
  endtask

  // One clock: drive inputs from the models at negedge, sample, then apply the pops the DUT commits at posedge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ne[i]            = (fq[i].size() != 0);
      bus.req_rd_data[8*i +: 8] = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
    end
    bus.tx_fifo_re = uart_re;
    #1;
    o_grant = grant;
    o_busy  = busy;
    o_ne    = bus.tx_fifo_ne;
    o_data  = bus.tx_fifo_rd_data;
    o_re    = bus.req_re;
    if (bus.tx_fifo_re && bus.tx_fifo_ne) uart_q.push_back(bus.tx_fifo_rd_data);
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_re[i]) begin
        rx_q.push_back({4'(i), (fq[i].size() != 0) ? fq[i][0] : 8'hXX});
        if (fq[i].size() != 0) void'(fq[i].pop_front());
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_l         = 1'b0;
    uart_re         = 1'b0;
    bus.req_ne      = '0;
    bus.req_rd_data = '0;
    bus.tx_fifo_re  = 1'b0;
    clear_models();
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic test_reset();
    reset_l         = 1'b0;
    bus.req_ne      = '1;
    bus.req_rd_data = {NREQ{8'h55}};
    bus.tx_fifo_re  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got %b want 0", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bus.tx_fifo_ne !== 1'b0) begin errors++; $display("FAIL reset_ne got %b want 0", bus.tx_fifo_ne); end
    checks++; if (bus.tx_fifo_rd_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.tx_fifo_rd_data); end
    checks++; if (bus.req_re !== '0) begin errors++; $display("FAIL reset_re got %b want 0", bus.req_re); end
    bus.req_ne     = '0;
    bus.tx_fifo_re = 1'b0;
    reset_l        = 1'b1;
    tick();
    checks++; if (o_grant !== '0 || o_busy !== 1'b0) begin errors++; $display("FAIL reset_idle grant %b busy %b want 0 0", o_grant, o_busy); end
  endtask

  task automatic test_single();
    logic [3:0] exp_g [6];
    int pulses = 0;
    string es = "AB\n";
    exp_g = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
    do_reset();
    load(1, es);
    uart_re = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (o_re[1]) pulses++;
      checks++;
      if (o_grant !== exp_g[t] || o_busy !== (exp_g[t] != 4'h0)) begin
        errors++; $display("FAIL single_grant t%0d got %b/%b want %b", t, o_grant, o_busy, exp_g[t]);
      end
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL single_pulses got %0d want 3", pulses); end
    checks++;
    if (uart_q.size() !== 3) begin errors++; $display("FAIL single_len got %0d want 3", uart_q.size()); end
    else for (int k = 0; k < 3; k++) begin
      if (uart_q[k] !== 8'(es[k])) begin errors++; $display("FAIL single_byte%0d got %h want %h", k, uart_q[k], es[k]); end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [13];
    int srcs [8];
    string es = "X\nX\nY\nY\n";
    exp_g = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0};
    srcs  = '{0, 0, 2, 2, 0, 0, 2, 2};
    do_reset();
    load(0, "X\nY\n");
    load(2, "X\nY\n");
    uart_re = 1'b1;
    for (int t = 0; t < 13; t++) begin
      tick();
      checks++;
      if (o_grant !== exp_g[t]) begin errors++; $display("FAIL fair_grant t%0d got %b want %b", t, o_grant, exp_g[t]); end
    end
    checks++;
    if (rx_q.size() !== 8) begin errors++; $display("FAIL fair_len got %0d want 8", rx_q.size()); end
    else for (int k = 0; k < 8; k++) begin
      if (rx_q[k] !== {4'(srcs[k]), 8'(es[k])}) begin
        errors++; $display("FAIL fair_stream%0d got %h want %h", k, rx_q[k], {4'(srcs[k]), 8'(es[k])});
      end
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp_g [17];
    int srcs [12];
    string es = "abcdefghQ\nij";
    exp_g = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h8, 4'h8, 4'h8,
              4'h8, 4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h8};
    srcs  = '{3, 3, 3, 3, 3, 3, 3, 3, 1, 1, 3, 3};
    do_reset();
    load(3, "abcdefghij");
    uart_re = 1'b1;
    for (int t = 0; t < 17; t++) begin
      if (t == 8) load(1, "Q\n");
      tick();
      checks++;
      if (o_grant !== exp_g[t]) begin errors++; $display("FAIL burst_grant t%0d got %b want %b", t, o_grant, exp_g[t]); end
    end
    checks++;
    if (rx_q.size() !== 12) begin errors++; $display("FAIL burst_len got %0d want 12", rx_q.size()); end
    else for (int k = 0; k < 12; k++) begin
      if (rx_q[k] !== {4'(srcs[k]), 8'(es[k])}) begin
        errors++; $display("FAIL burst_stream%0d got %h want %h", k, rx_q[k], {4'(srcs[k]), 8'(es[k])});
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] eg;
    int stray = 0;
    do_reset();
    load(0, "AB");
    uart_re = 1'b1;
    for (int t = 0; t < 23; t++) begin
      if (t == 5) load(1, "W\n");
      tick();
      eg = (t == 0 || t == 19 || t == 22) ? 4'h0 : (t <= 18) ? 4'h1 : 4'h2;
      checks++;
      if (o_grant !== eg || o_busy !== (eg != 4'h0)) begin
        errors++; $display("FAIL tmo_grant t%0d got %b/%b want %b", t, o_grant, o_busy, eg);
      end
      if (t >= 3 && t <= 18 && (o_re !== '0 || o_ne !== 1'b0)) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL tmo_empty_pops got %0d want 0", stray); end
    checks++;
    if (rx_q.size() !== 4 || rx_q[0] !== 12'h041 || rx_q[1] !== 12'h042 || rx_q[2] !== 12'h157 || rx_q[3] !== 12'h10A) begin
      errors++; $display("FAIL tmo_stream got %0d entries want 041 042 157 10A", rx_q.size());
    end
  endtask

  task automatic test_spurious_reset();
    string es = "LONG\n";
    int bad = 0;
    do_reset();
    uart_re = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (o_re !== '0 || o_grant !== '0 || o_ne !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL spurious_pop got %0d bad cycles want 0", bad); end
    load(2, es);
    repeat (3) tick();
    checks++; if (o_grant !== 4'h4) begin errors++; $display("FAIL midmsg_grant got %b want 0100", o_grant); end
    @(posedge clk);
    #2;
    reset_l = 1'b0;
    #1;
    checks++; if (grant !== '0) begin errors++; $display("FAIL areset_grant got %b want 0", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
    checks++; if (bus.req_re !== '0) begin errors++; $display("FAIL areset_re got %b want 0", bus.req_re); end
    checks++; if (bus.tx_fifo_ne !== 1'b0) begin errors++; $display("FAIL areset_ne got %b want 0", bus.tx_fifo_ne); end
    @(negedge clk);
    reset_l = 1'b1;
    repeat (9) tick();
    checks++;
    if (rx_q.size() !== 5) begin errors++; $display("FAIL reset_stream_len got %0d want 5", rx_q.size()); end
    else for (int k = 0; k < 5; k++) begin
      if (rx_q[k] !== {4'd2, 8'(es[k])}) begin
        errors++; $display("FAIL reset_stream%0d got %h want %h", k, rx_q[k], {4'd2, 8'(es[k])});
      end
    end
  endtask

`ifdef UART_ARB_TAG_EN
  task automatic test_tag();
    int pulses = 0;
    do_reset();
    load(2, "Z\n");
    uart_re = 1'b1;
    tick();
    tick();
    checks++;
    if (o_grant !== 4'h4 || o_ne !== 1'b1 || o_data !== 8'h32 || o_re !== '0) begin
      errors++; $display("FAIL tag_cycle grant %b ne %b data %h re %b want 0100 1 32 0000", o_grant, o_ne, o_data, o_re);
    end
    for (int t = 0; t < 4; t++) begin
      tick();
      if (o_re[2]) pulses++;
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL tag_pulses got %0d want 2", pulses); end
    checks++; if (o_grant !== '0) begin errors++; $display("FAIL tag_release got %b want 0", o_grant); end
    checks++;
    if (uart_q.size() !== 3 || uart_q[0] !== 8'h32 || uart_q[1] !== 8'h5A || uart_q[2] !== 8'h0A) begin
      errors++; $display("FAIL tag_stream got %0d bytes want 32 5A 0A", uart_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef UART_ARB_TAG_EN
    test_spurious_reset();
    test_tag();
`else
    test_single();
    test_fairness();
    test_burst();
    test_timeout();
    test_spurious_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
